dwa_thermo_decoder: RTL

Parametrised, clocked successor to the fixed 4-bit thermometer decoder in the sigma-delta DAC path. It converts a CODE_W-bit modulator output code into N = 2^CODE_W − 1 unit-element enables. In DWA mode it applies data-weighted-averaging rotation so element mismatch is first-order noise-shaped. It sits between the multibit sigma-delta modulator and the unit-element DAC drivers, and registers its outputs so the analog drivers see glitch-free enables.

---
 rtl/dwa_thermo_decoder.sv | 78 +++++++
 1 files changed

// File: rtl/dwa_thermo_decoder.sv
// Thermometer decoder for a multibit sigma-delta DAC with optional data-weighted-averaging
// rotation; element enables are registered so the unit-element drivers see glitch-free levels.
module dwa_thermo_decoder #(
    parameter int CODE_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          code_valid,
    input  logic [CODE_W-1:0]             code,
    input  logic                          mode,
    output logic [(1 << CODE_W) - 2:0]    elem,
    output logic                          elem_valid,
    output logic [CODE_W-1:0]             ptr
);
    localparam int N = (1 << CODE_W) - 1;
    localparam logic [CODE_W:0] N_W = (CODE_W + 1)'(N);

    generate
        if (CODE_W < 2 || CODE_W > 6) begin : g_bad_code_w
            $error("dwa_thermo_decoder: CODE_W must be in 2..6");
        end
    endgenerate

    // (1 << c) - 1 computed one bit wider so c = N yields all N ones.
    function automatic logic [N-1:0] thermo_word(input logic [CODE_W-1:0] c);
        logic [N:0] t;
        t = ((N + 1)'(1) << c) - (N + 1)'(1);
        return t[N-1:0];
    endfunction

    // Rotate left by p modulo N: the upper half of the doubled word shifted by p.
    function automatic logic [N-1:0] rotl_mod_n(input logic [N-1:0] t, input logic [CODE_W-1:0] p);
        logic [2*N-1:0] d;
        d = {t, t} << p;
        return d[2*N-1:N];
    endfunction

    function automatic logic [CODE_W-1:0] wrap_add(input logic [CODE_W-1:0] p, input logic [CODE_W-1:0] c);
        logic [CODE_W:0] s;
        s = {1'b0, p} + {1'b0, c};
        if (s >= N_W) begin
            s = s - N_W;
        end
        return s[CODE_W-1:0];
    endfunction

    logic [N-1:0]      thermo_p0;
    logic [N-1:0]      rot_p0;
    logic [CODE_W-1:0] ptr_next_p0;
    logic [N-1:0]      elem_p1;
    logic              vld_p1;
    logic [CODE_W-1:0] ptr_p1;

    always_comb begin
        thermo_p0   = thermo_word(code);
        rot_p0      = rotl_mod_n(thermo_p0, ptr_p1);
        ptr_next_p0 = wrap_add(ptr_p1, code);
    end

    // p0 -> p1: register enables, pointer and valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_p1 <= '0;
            vld_p1  <= 1'b0;
            ptr_p1  <= '0;
        end else begin
            vld_p1 <= code_valid;
            if (code_valid) begin
                elem_p1 <= mode ? rot_p0 : thermo_p0;
                ptr_p1  <= mode ? ptr_next_p0 : '0;
            end
        end
    end

    assign elem       = elem_p1;
    assign elem_valid = vld_p1;
    assign ptr        = ptr_p1;
endmodule
